// File: rtl/issue_queue.sv
// issue_queue: in-order instruction buffer between fetch and issue.
// Circular buffer with head/tail pointers and a separate occupancy counter.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// exactly when valid and ready are both high in that cycle; valid never
// depends on ready of the same port, and fetch_ready_o depends only on
// registered state (never on issue_ready_i). flush_i cancels both transfers.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [ILEN-1:0]          fetch_instr_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [XLEN-1:0]          issue_pc_o,
  output logic [ILEN-1:0]          issue_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [ILEN-1:0] instr_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign fetch_ready_o = (count_q != CW'(DEPTH));
  assign issue_valid_o = (count_q != '0);
  assign issue_pc_o    = pc_mem_q[head_q];
  assign issue_instr_o = instr_mem_q[head_q];
  assign count_o       = count_q;

  assign push = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop  = issue_valid_o && issue_ready_i && !flush_i;

  // Next-state for pointers and occupancy; flush empties and rewinds to slot 0.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and counter registers; reset behaves like a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: written only on an accepted push, contents never reset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem_q[tail_q]    <= fetch_pc_i;
      instr_mem_q[tail_q] <= fetch_instr_i;
    end
  end

endmodule
